resp_deser_16: RTL and testbench
================================

// Module: resp_deser_16
// PURPOSE
//   Serial-to-parallel collector for the serial PUF datapath; the inverse of the 16:1 select path.
//   Each accepted serial response bit is demultiplexed into the slot given by an internal
//   4-bit index. The index is exported so upstream can drive its mux select in lockstep.
//   A full 16-bit word is handed off through a valid/ready output register while the next word
//   is collected into a separate shadow register.
// PARAMETERS
//   WIDTH      16  bits per word; must equal 2**SEL_W
//   SEL_W      4   width of slot index / sel_out
//   MSB_FIRST  0   0: first serial bit -> word_out[0]; 1: first serial bit -> word_out[WIDTH-1]
// PORTS
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous reset, active-high
//   bit_in      in   1        serial response bit
//   bit_valid   in   1        bit_in is valid this cycle
//   bit_ready   out  1        block can accept bit_in this cycle
//   clear       in   1        sync abort of the partial word (shadow + index only)
//   sel_out     out  SEL_W    slot index the next accepted bit is written to
//   word_out    out  WIDTH    completed parallel word
//   word_valid  out  1        word_out holds an unconsumed word
//   word_ready  in   1        downstream consumes word_out when word_valid & word_ready
//   drop_err    out  1        sticky: bit_valid seen while bit_ready=0
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): idx=0, shadow=0, word_out=0, word_valid=0, drop_err=0.
//     rst overrides clear and all handshakes. rst mid-word discards the partial word.
//   - Accept = bit_valid & bit_ready. On accept, shadow[slot]<=bit_in and idx<=idx+1,
//     wrapping from WIDTH-1 to 0. slot = idx (MSB_FIRST=0) or WIDTH-1-idx (MSB_FIRST=1).
//   - sel_out = idx (registered). It advances only on accept.
//   - Completion is an accept with idx==WIDTH-1. On that edge:
//     word_out <= shadow with the final bit merged in, word_valid <= 1, idx <= 0.
//   - Latency: word_valid rises the cycle after the edge that accepts the last bit.
//   - Pop = word_valid & word_ready. Pop without completion: word_valid <= 0; word_out holds its value.
//   - Pop and completion on the same edge: the new word loads and word_valid stays 1.
//   - bit_ready = ~(idx==WIDTH-1 & word_valid & ~word_ready).
//     This is combinational on word_ready: the last bit stalls only while the output is full and not draining.
//   - Bits 0..WIDTH-2 of the next word are always accepted (double buffering).
//   - bit_valid & ~bit_ready: the bit is ignored, idx is unchanged, drop_err <= 1.
//     drop_err stays set until rst.
//   - clear=1: idx <= 0, shadow <= 0, and any bit in the same cycle is ignored.
//     word_out, word_valid and the output handshake are unaffected.
//   - clear has priority over accept. A pop in the same cycle as clear still completes.
//   - No other state; no combinational path from bit_in to any output.
// TESTING
//   1. rst 2 cycles -> word_out=0, word_valid=0, sel_out=0, bit_ready=1, drop_err=0.
//   2. MSB_FIRST=0, word_ready=1, 16 back-to-back bits of 16'hA5C3 LSB first
//      -> sel_out counts 0..15; word_valid=1 one cycle after the 16th bit; word_out=16'hA5C3; sel_out=0.
//   3. word_ready=0, stream 16'h1234 then 16'hBEEF
//      -> 15 bits of the second word accepted; bit_ready=0 at sel_out=15; word_out stays 16'h1234.
//      Then raise word_ready for 1 cycle -> 16th bit accepted that edge; next word_out=16'hBEEF.
//   4. bit_valid toggled randomly, gaps up to 5 cycles
//      -> word_out identical to gap-free run; sel_out holds during gaps.
//   5. After 7 bits assert clear 1 cycle, then 16 bits of 16'h00FF
//      -> word_out=16'h00FF; the earlier word is untouched if still pending.
//   6. Hold bit_valid=1 during stall of test 3 -> drop_err=1 and stays 1.
//      rst mid-word -> all outputs return to reset values.
//   Repeat tests 2 and 3 with MSB_FIRST=1 -> the first bit lands in word_out[15].

Source files
------------

// File: rtl/resp_deser_16.sv
// Serial-to-parallel collector for the PUF response path: demuxes accepted bits into a shadow
// word indexed by sel_out, then hands completed words off through a valid/ready output register.
module resp_deser_16 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SEL_W     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             clear,
  output logic [SEL_W-1:0] sel_out,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             drop_err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] merged;
  logic [SEL_W-1:0] slot;
  logic             at_last;
  logic             accept;
  logic             take;
  logic             complete;
  logic             pop;

  assign at_last = (idx == LAST);
  assign sel_out = idx;

  // Only the final bit of a word can stall: the output is full and not draining.
  assign bit_ready = ~(at_last & word_valid & ~word_ready);

  assign accept   = bit_valid & bit_ready;
  assign take     = accept & ~clear;
  assign complete = take & at_last;
  assign pop      = word_valid & word_ready;
  assign slot     = MSB_FIRST ? (LAST - idx) : idx;

  always_comb begin
    merged       = shadow;
    merged[slot] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      shadow     <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      if (bit_valid & ~bit_ready) begin
        drop_err <= 1'b1;
      end

      // Collection side: clear aborts the partial word and wins over an accept.
      if (clear) begin
        idx    <= '0;
        shadow <= '0;
      end else if (take) begin
        if (at_last) begin
          idx    <= '0;
          shadow <= '0;
        end else begin
          idx    <= idx + SEL_W'(1);
          shadow <= merged;
        end
      end

      // Output side: a completion reloads even when the old word pops on the same edge.
      if (complete) begin
        word_out   <= merged;
        word_valid <= 1'b1;
      end else if (pop) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_resp_deser_16.sv
// Directed bench for resp_deser_16; LSB-first and MSB-first instances share one stimulus stream.
module tb_resp_deser_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        clear;
  logic        word_ready;
  logic        bit_ready0, bit_ready1;
  logic [3:0]  sel0, sel1;
  logic [15:0] word0, word1;
  logic        wv0, wv1;
  logic        de0, de1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  resp_deser_16 #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready0),
    .clear(clear), .sel_out(sel0), .word_out(word0), .word_valid(wv0),
    .word_ready(word_ready), .drop_err(de0)
  );

  resp_deser_16 #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready1),
    .clear(clear), .sel_out(sel1), .word_out(word1), .word_valid(wv1),
    .word_ready(word_ready), .drop_err(de1)
  );

  typedef struct {
    logic        valid;
    logic        din;
    logic        clr;
    logic        wrdy;
    logic [3:0]  sel;
    logic        brdy;
    logic        wv;
    logic [15:0] word;
    logic        chk_word;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word for the LSB-first instance; the MSB-first instance must hold its bit reversal.
  task automatic check_word(input string name, input logic [15:0] exp);
    check({name, "_lsb"}, 32'(word0), 32'(exp));
    check({name, "_msb"}, 32'(word1), 32'(rev16(exp)));
  endtask

  task automatic check_state(input string name, input logic [3:0] sel, input logic wv,
                             input logic brdy);
    check({name, "_sel0"}, 32'(sel0), 32'(sel));
    check({name, "_sel1"}, 32'(sel1), 32'(sel));
    check({name, "_wv0"}, 32'(wv0), 32'(wv));
    check({name, "_wv1"}, 32'(wv1), 32'(wv));
    check({name, "_brdy0"}, 32'(bit_ready0), 32'(brdy));
    check({name, "_brdy1"}, 32'(bit_ready1), 32'(brdy));
  endtask

  task automatic check_drop(input string name, input logic exp);
    check({name, "_de0"}, 32'(de0), 32'(exp));
    check({name, "_de1"}, 32'(de1), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic c, input logic r);
    bit_valid  = v;
    bit_in     = b;
    clear      = c;
    word_ready = r;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic add_vec(input logic v, input logic b, input logic r, input logic [3:0] sel,
                         input logic brdy, input logic wv, input logic [15:0] word,
                         input logic chk);
    vec_t x;
    x.valid = v; x.din = b; x.clr = 1'b0; x.wrdy = r; x.sel = sel;
    x.brdy = brdy; x.wv = wv; x.word = word; x.chk_word = chk;
    tbl.push_back(x);
  endtask

  logic [15:0] w2;
  logic [15:0] w3a;
  logic [15:0] w3b;
  logic [15:0] w4;
  logic [15:0] w5;
  logic [15:0] w6;

  initial begin
    w2  = 16'hA5C3;
    w3a = 16'h1234;
    w3b = 16'hBEEF;
    w4  = 16'h5A3C;
    w5  = 16'h00FF;
    w6  = 16'h8001;

    // Test 2 vectors: outputs are checked before the edge that applies the row's inputs.
    for (int i = 0; i < 16; i++)
      add_vec(1'b1, w2[i], 1'b1, 4'(i), 1'b1, 1'b0, 16'h0000, i == 0);
    add_vec(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 16'hA5C3, 1'b1);
    add_vec(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 16'hA5C3, 1'b1);

    // Test 1: reset
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_state("reset", 4'd0, 1'b0, 1'b1);
    check_word("reset_word", 16'h0000);
    check_drop("reset", 1'b0);

    // Test 2: back-to-back word, downstream always ready
    foreach (tbl[k]) begin
      drive(tbl[k].valid, tbl[k].din, tbl[k].clr, tbl[k].wrdy);
      #1;
      check_state($sformatf("t2_row%0d", k), tbl[k].sel, tbl[k].wv, tbl[k].brdy);
      if (tbl[k].chk_word) check_word($sformatf("t2_word%0d", k), tbl[k].word);
      @(posedge clk);
      #1;
    end
    check_drop("t2", 1'b0);

    // Tests 3 and 6: output held, last bit of the second word stalls, then drains
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send_word(w3a, 16);
    check_state("t3_first", 4'd0, 1'b1, 1'b1);
    check_word("t3_first", 16'h1234);
    send_word(w3b, 15);
    bit_valid = 1'b1;
    bit_in    = w3b[15];
    #1;
    check_state("t3_stall", 4'd15, 1'b1, 1'b0);
    repeat (3) tick();
    check_state("t3_held", 4'd15, 1'b1, 1'b0);
    check_word("t3_held", 16'h1234);
    check_drop("t3_drop", 1'b1);
    word_ready = 1'b1;
    #1;
    check("t3_release_brdy0", 32'(bit_ready0), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_state("t3_second", 4'd0, 1'b1, 1'b1);
    check_word("t3_second", 16'hBEEF);
    check_drop("t3_sticky", 1'b1);
    word_ready = 1'b1;
    tick();
    check_state("t3_drained", 4'd0, 1'b0, 1'b1);

    // Test 4: random gaps between bits
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, ~w4[i], 1'b0, 1'b1);
        #1;
        check($sformatf("t4_gap_sel_b%0d", i), 32'(sel0), 32'(i));
        tick();
      end
      send_bit(w4[i]);
    end
    check_state("t4_done", 4'd0, 1'b1, 1'b1);
    check_word("t4_word", 16'h5A3C);
    tick();

    // Test 5: clear mid-word with an older word still pending
    word_ready = 1'b0;
    send_word(w5 ^ 16'h3C96, 16);
    send_word(16'hFFFF, 7);
    check("t5_pre_clear_sel", 32'(sel0), 32'd7);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_state("t5_cleared", 4'd0, 1'b1, 1'b1);
    check_word("t5_pending", 16'h3C69);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_state("t5_pop_with_clear", 4'd0, 1'b0, 1'b1);
    check_word("t5_pop_hold", 16'h3C69);
    send_word(w5, 16);
    check_state("t5_done", 4'd0, 1'b1, 1'b1);
    check_word("t5_word", 16'h00FF);
    tick();

    // Test 6: reset mid-word with a word pending and drop_err set
    word_ready = 1'b0;
    send_word(w6, 16);
    send_word(16'h001F, 5);
    check("t6_pre_rst_sel", 32'(sel0), 32'd5);
    check_word("t6_pending", 16'h8001);
    rst = 1'b1;
    bit_valid = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_state("t6_rst", 4'd0, 1'b0, 1'b1);
    check_word("t6_rst", 16'h0000);
    check_drop("t6_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
